rep_sequencer: RTL and testbench
================================

// Module: rep_sequencer
// PURPOSE
//  Sequences REP/REPE/REPNE string instructions after register-read/address-generation. It latches the
//  initial count (ECX/CX) and the two linear string addresses, then issues one iteration per downstream
//  handshake. Addresses step by operand size in the direction given by DF; the count decrements per step.
//  For REPE/REPNE it waits for the execute-stage ZF after each iteration. Upstream is held while busy.
// PARAMETERS
//  ADDR_WIDTH  32  width of linear addresses addr1/addr2 (wrap modulo 2^ADDR_WIDTH)
//  CNT_WIDTH   32  width of the repeat counter (ECX)
// PORTS
//  clk          in   1           clock
//  clr          in   1           asynchronous active-low reset
//  start_valid  in   1           address-gen stage output valid this cycle
//  is_rep       in   1           instruction carries a REP prefix
//  rep_cond     in   2           00 REP, 01 REPE (stop on ZF=0), 10 REPNE (stop on ZF=1), 11 = REP
//  rep_num      in   CNT_WIDTH   initial count (ECX)
//  addressingmode in 1           1 = 32b count, 0 = 16b count (rep_num[15:0] only)
//  addr1_in     in   ADDR_WIDTH  source linear address (mem_addr1)
//  addr2_in     in   ADDR_WIDTH  destination linear address (mem_addr2)
//  opsize       in   2           00=1B 01=2B 10=4B 11=8B step size
//  df           in   1           direction flag; 0 increment, 1 decrement
//  out_ready    in   1           downstream latch accepts the iteration
//  zf_valid     in   1           execute-stage ZF result for the outstanding iteration
//  zf           in   1           that ZF value
//  flush        in   1           pipeline flush (mispredict/exception)
//  stall_up     out  1           hold upstream latch; = (state != IDLE)
//  iter_valid   out  1           iteration presented downstream
//  iter_addr1   out  ADDR_WIDTH  iteration source address
//  iter_addr2   out  ADDR_WIDTH  iteration destination address
//  iter_cnt     out  CNT_WIDTH   count before this iteration
//  iter_last    out  1           final iteration by count (iter_cnt == 1)
//  done         out  1           one-cycle pulse: sequence finished normally
// BEHAVIOUR
//  - Reset (clr=0, async): state IDLE; all outputs 0; internal cnt/addr registers 0.
//  - States: IDLE, ISSUE, WAITZF. iter_valid = (state==ISSUE). Outputs come from registers (no comb path
//    from addr*_in); stall_up depends on state only.
//  - IDLE: accept when start_valid & is_rep. Latch cnt = addressingmode ? rep_num : {0,rep_num[15:0]},
//    addr1/addr2, step = 1<<opsize, df, rep_cond. If latched cnt==0: stay IDLE, pulse done next cycle,
//    no iteration. Else go ISSUE next cycle. start_valid & !is_rep is ignored.
//  - ISSUE: hold iter_* stable while out_ready=0. On iter_valid & out_ready: cnt<=cnt-1,
//    addrN<=df ? addrN-step : addrN+step (modulo 2^ADDR_WIDTH).
//    If cnt==1: go IDLE, done pulses the following cycle (for REPE/REPNE the ZF is not waited for).
//    Else if rep_cond in {01,10}: go WAITZF. Else stay ISSUE (one iteration per cycle at full throughput).
//  - WAITZF: iter_valid=0. On zf_valid: REPE & zf=0, or REPNE & zf=1 -> IDLE + done pulse;
//    otherwise -> ISSUE. zf_valid outside WAITZF is ignored.
//  - flush: from any state -> IDLE next cycle, no done, outstanding iteration dropped; flush beats
//    zf_valid/out_ready/start_valid in the same cycle; no accept in the flush cycle.
//  - Reset mid-operation: immediate IDLE, no done.
//  - done is asserted exactly one cycle per completed sequence; never with iter_valid of a new sequence.
//  - Back-to-back: a new start may be accepted in the cycle after return to IDLE.
// TESTING
//  1. rep_num=3, cond=00, opsize=10, df=0, a1=0x1000, a2=0x2000, ready=1 -> iter_valid 3 cycles,
//     a1=0x1000/0x1004/0x1008, a2=0x2000/0x2004/0x2008, iter_cnt 3/2/1, iter_last on 3rd; done next cycle.
//  2. rep_num=0 -> no iter_valid, stall_up stays 0, done pulses once the cycle after the accept.
//  3. df=1, opsize=00, a1=0x00000001, rep_num=3 -> a1=0x00000001, 0x00000000, 0xFFFFFFFF (wrap).
//  4. out_ready low 2 cycles during iteration 2 -> iter_addr1/2, iter_cnt held; total still 3 handshakes.
//  5. REPE, rep_num=5, ZF returned 1,1,0 -> exactly 3 iterations, iter_valid low in WAITZF, done after 3rd ZF.
//  6. addressingmode=0, rep_num=0x00010002 -> 2 iterations; flush in WAITZF, and clr low in ISSUE
//     -> IDLE next cycle / immediately, no done, stall_up 0.

Source files
------------

// File: rtl/rep_sequencer.sv
// REP/REPE/REPNE string-instruction sequencer: latches count and addresses, then issues one
// iteration per downstream handshake, optionally waiting for execute-stage ZF between iterations.
//  state  | meaning
//  IDLE   | no sequence active; accepts a REP-prefixed start
//  ISSUE  | iteration presented downstream, waiting for out_ready_i
//  WAITZF | REPE/REPNE iteration issued, waiting for its ZF result
module rep_sequencer #(
   parameter int ADDR_WIDTH = 32,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                  clk_i,
   input  logic                  rst_n_i,
   input  logic                  start_valid_i,
   input  logic                  is_rep_i,
   input  logic [1:0]            rep_cond_i,
   input  logic [CNT_WIDTH-1:0]  rep_num_i,
   input  logic                  addressingmode_i,
   input  logic [ADDR_WIDTH-1:0] addr1_in_i,
   input  logic [ADDR_WIDTH-1:0] addr2_in_i,
   input  logic [1:0]            opsize_i,
   input  logic                  df_i,
   input  logic                  out_ready_i,
   input  logic                  zf_valid_i,
   input  logic                  zf_i,
   input  logic                  flush_i,
   output logic                  stall_up_o,
   output logic                  iter_valid_o,
   output logic [ADDR_WIDTH-1:0] iter_addr1_o,
   output logic [ADDR_WIDTH-1:0] iter_addr2_o,
   output logic [CNT_WIDTH-1:0]  iter_cnt_o,
   output logic                  iter_last_o,
   output logic                  done_o
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAITZF} state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
   localparam logic [1:0]           COND_REPE  = 2'b01;
   localparam logic [1:0]           COND_REPNE = 2'b10;

   state_t                  state_q;
   logic [CNT_WIDTH-1:0]    cnt_q;
   logic [ADDR_WIDTH-1:0]   addr1_q;
   logic [ADDR_WIDTH-1:0]   addr2_q;
   logic [1:0]              opsize_q;
   logic                    df_q;
   logic [1:0]              cond_q;
   logic                    done_q;

   logic [CNT_WIDTH-1:0]    start_cnt_d;
   logic [ADDR_WIDTH-1:0]   step_d;
   logic [ADDR_WIDTH-1:0]   addr1_d;
   logic [ADDR_WIDTH-1:0]   addr2_d;
   logic                    zf_stop_d;

   // 16-bit addressing only honours CX
   assign start_cnt_d = addressingmode_i ? rep_num_i
                                         : {{(CNT_WIDTH-16){1'b0}}, rep_num_i[15:0]};
   assign step_d      = {{(ADDR_WIDTH-4){1'b0}}, 4'b0001 << opsize_q};
   assign addr1_d     = df_q ? addr1_q - step_d : addr1_q + step_d;
   assign addr2_d     = df_q ? addr2_q - step_d : addr2_q + step_d;
   assign zf_stop_d   = ((cond_q == COND_REPE) && !zf_i) || ((cond_q == COND_REPNE) && zf_i);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         addr1_q  <= '0;
         addr2_q  <= '0;
         opsize_q <= '0;
         df_q     <= 1'b0;
         cond_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (flush_i) begin
            state_q <= IDLE;
         end else begin
            case (state_q)
               IDLE: begin
                  if (start_valid_i && is_rep_i) begin
                     cnt_q    <= start_cnt_d;
                     addr1_q  <= addr1_in_i;
                     addr2_q  <= addr2_in_i;
                     opsize_q <= opsize_i;
                     df_q     <= df_i;
                     cond_q   <= rep_cond_i;
                     if (start_cnt_d == CNT_ZERO) done_q  <= 1'b1;
                     else                         state_q <= ISSUE;
                  end
               end
               ISSUE: begin
                  if (out_ready_i) begin
                     cnt_q   <= cnt_q - CNT_ONE;
                     addr1_q <= addr1_d;
                     addr2_q <= addr2_d;
                     // count exhaustion ends the sequence without waiting for ZF
                     if (cnt_q == CNT_ONE) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                     end else if (cond_q == COND_REPE || cond_q == COND_REPNE) begin
                        state_q <= WAITZF;
                     end
                  end
               end
               WAITZF: begin
                  if (zf_valid_i) begin
                     if (zf_stop_d) begin
                        state_q <= IDLE;
                        done_q  <= 1'b1;
                     end else begin
                        state_q <= ISSUE;
                     end
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign stall_up_o   = (state_q != IDLE);
   assign iter_valid_o = (state_q == ISSUE);
   assign iter_addr1_o = addr1_q;
   assign iter_addr2_o = addr2_q;
   assign iter_cnt_o   = cnt_q;
   assign iter_last_o  = (state_q == ISSUE) && (cnt_q == CNT_ONE);
   assign done_o       = done_q;

endmodule

// File: tb/tb_rep_sequencer.sv
// Bench for rep_sequencer: directed and randomized sequences checked against a transaction-level
// model that derives each iteration's addresses and count from the start values by arithmetic.
module tb_rep_sequencer;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start_valid, is_rep, addressingmode, df, out_ready, zf_valid, zf, flush;
   logic [1:0]  rep_cond, opsize;
   logic [31:0] rep_num, addr1_in, addr2_in;
   logic        stall_up, iter_valid, iter_last, done;
   logic [31:0] iter_addr1, iter_addr2, iter_cnt;

   int vectors = 0;
   int errs    = 0;

   always #5 clk = ~clk;

   rep_sequencer #(.ADDR_WIDTH(32), .CNT_WIDTH(32)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .start_valid_i(start_valid), .is_rep_i(is_rep), .rep_cond_i(rep_cond),
      .rep_num_i(rep_num), .addressingmode_i(addressingmode),
      .addr1_in_i(addr1_in), .addr2_in_i(addr2_in), .opsize_i(opsize), .df_i(df),
      .out_ready_i(out_ready), .zf_valid_i(zf_valid), .zf_i(zf), .flush_i(flush),
      .stall_up_o(stall_up), .iter_valid_o(iter_valid),
      .iter_addr1_o(iter_addr1), .iter_addr2_o(iter_addr2), .iter_cnt_o(iter_cnt),
      .iter_last_o(iter_last), .done_o(done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_inputs();
      start_valid = 1'b0; is_rep = 1'b0; out_ready = 1'b0;
      zf_valid = 1'b0; zf = 1'b0; flush = 1'b0;
   endtask

   task automatic present_start(input logic [31:0] num, input bit mode, input logic [1:0] cond,
                                input logic [31:0] a1, input logic [31:0] a2,
                                input logic [1:0] os, input bit d);
      start_valid = 1'b1; is_rep = 1'b1; rep_num = num; addressingmode = mode;
      rep_cond = cond; addr1_in = a1; addr2_in = a2; opsize = os; df = d;
   endtask

   // One full sequence. Expected iteration k: addr = start +/- k*size, count = initial - k.
   // rnd: random ready/zf timing; otherwise ready=1 except 2 low cycles at iteration stall_at,
   // and ZF after iteration j is zfpat[j].
   task automatic run_seq(input logic [31:0] num, input bit mode, input logic [1:0] cond,
                          input logic [31:0] a1, input logic [31:0] a2, input logic [1:0] os,
                          input bit d, input bit rnd, input int stall_at, input logic [31:0] zfpat);
      logic [31:0] c, step, off, e1, e2;
      int          k, budget, hold;
      bit          finished, waiting, exp_done, exp_valid, is_cond, stop;
      c       = mode ? num : {16'h0, num[15:0]};
      step    = 32'd1 << os;
      is_cond = (cond == 2'b01) || (cond == 2'b10);
      @(negedge clk);
      present_start(num, mode, cond, a1, a2, os, d);
      out_ready = rnd ? 1'($urandom_range(1)) : 1'b1;
      zf_valid  = rnd ? 1'($urandom_range(1)) : 1'b0;
      k = 0; hold = 0; budget = 0; waiting = 1'b0;
      finished = (c == 32'd0);
      exp_done = (c == 32'd0);
      while (budget < 400) begin
         @(negedge clk);
         budget++;
         exp_valid = !finished && !waiting;
         chk("iter_valid", {31'd0, iter_valid}, {31'd0, exp_valid});
         chk("stall_up", {31'd0, stall_up}, {31'd0, !finished});
         chk("done", {31'd0, done}, {31'd0, exp_done});
         if (exp_valid) begin
            off = 32'(k) * step;
            e1  = d ? a1 - off : a1 + off;
            e2  = d ? a2 - off : a2 + off;
            chk("iter_addr1", iter_addr1, e1);
            chk("iter_addr2", iter_addr2, e2);
            chk("iter_cnt", iter_cnt, c - 32'(k));
            chk("iter_last", {31'd0, iter_last}, {31'd0, (c - 32'(k)) == 32'd1});
         end
         if (finished && !exp_done) break;
         start_valid = 1'b0; is_rep = 1'b0;
         addr1_in = $urandom; addr2_in = $urandom; rep_num = $urandom;
         exp_done = 1'b0; zf_valid = 1'b0; out_ready = 1'b0;
         if (exp_valid) begin
            if (rnd) begin
               out_ready = ($urandom_range(3) != 0);
               zf_valid  = 1'($urandom_range(1));
               zf        = 1'($urandom_range(1));
            end else begin
               out_ready = !(k == stall_at && hold < 2);
               if (!out_ready) hold++;
            end
            if (out_ready) begin
               k++;
               if (32'(k) == c) begin
                  finished = 1'b1; exp_done = 1'b1;
               end else if (is_cond) begin
                  waiting = 1'b1;
               end
            end
         end else if (waiting) begin
            if (rnd) begin
               zf_valid = ($urandom_range(2) != 0);
               stop     = ($urandom_range(3) == 0);
               zf       = (cond == 2'b01) ? !stop : stop;
            end else begin
               zf_valid = 1'b1;
               zf       = zfpat[k-1];
            end
            if (zf_valid) begin
               waiting = 1'b0;
               if ((cond == 2'b01) ? !zf : zf) begin
                  finished = 1'b1; exp_done = 1'b1;
               end
            end
         end
      end
      vectors++;
      assert (budget < 400) else begin
         errs++;
         $error("FAIL seq_timeout observed=%0d expected=<400", budget);
      end
      idle_inputs();
   endtask

   initial begin
      idle_inputs();
      rep_num = '0; addressingmode = 1'b1; rep_cond = 2'b00;
      addr1_in = '0; addr2_in = '0; opsize = 2'b00; df = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_stall", {31'd0, stall_up}, 32'd0);
      chk("rst_valid", {31'd0, iter_valid}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_addr1", iter_addr1, 32'd0);
      chk("rst_cnt", iter_cnt, 32'd0);
      rst_n = 1'b1;

      run_seq(32'd3, 1'b1, 2'b00, 32'h1000, 32'h2000, 2'b10, 1'b0, 1'b0, -1, 32'd0);
      run_seq(32'd0, 1'b1, 2'b00, 32'h1000, 32'h2000, 2'b10, 1'b0, 1'b0, -1, 32'd0);
      run_seq(32'd3, 1'b1, 2'b00, 32'h0000_0001, 32'h10, 2'b00, 1'b1, 1'b0, -1, 32'd0);
      run_seq(32'd3, 1'b1, 2'b00, 32'h3000, 32'h4000, 2'b01, 1'b0, 1'b0, 1, 32'd0);
      run_seq(32'd5, 1'b1, 2'b01, 32'h5000, 32'h6000, 2'b11, 1'b0, 1'b0, -1, 32'b011);
      run_seq(32'd5, 1'b1, 2'b10, 32'h5000, 32'h6000, 2'b00, 1'b1, 1'b0, -1, 32'b0100);
      run_seq(32'h0001_0002, 1'b0, 2'b11, 32'hFFFF_FFFC, 32'h8, 2'b10, 1'b0, 1'b0, -1, 32'd0);

      // start without REP prefix is ignored
      @(negedge clk);
      present_start(32'd3, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
      is_rep = 1'b0;
      @(negedge clk);
      idle_inputs();
      chk("norep_stall", {31'd0, stall_up}, 32'd0);
      chk("norep_done", {31'd0, done}, 32'd0);

      // flush while waiting for ZF beats a terminating ZF
      @(negedge clk);
      present_start(32'd3, 1'b1, 2'b01, 32'h100, 32'h200, 2'b00, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      chk("fl_valid", {31'd0, iter_valid}, 32'd1);
      start_valid = 1'b0; is_rep = 1'b0;
      @(negedge clk);
      chk("fl_wz_valid", {31'd0, iter_valid}, 32'd0);
      chk("fl_wz_stall", {31'd0, stall_up}, 32'd1);
      flush = 1'b1; zf_valid = 1'b1; zf = 1'b0;
      @(negedge clk);
      idle_inputs();
      chk("fl_stall", {31'd0, stall_up}, 32'd0);
      chk("fl_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      chk("fl_done2", {31'd0, done}, 32'd0);

      // flush blocks an accept in the same cycle
      present_start(32'd2, 1'b1, 2'b00, 32'h0, 32'h0, 2'b00, 1'b0);
      flush = 1'b1;
      @(negedge clk);
      idle_inputs();
      chk("flacc_stall", {31'd0, stall_up}, 32'd0);
      @(negedge clk);
      chk("flacc_done", {31'd0, done}, 32'd0);

      // asynchronous reset while issuing
      present_start(32'd5, 1'b1, 2'b00, 32'h700, 32'h800, 2'b00, 1'b0);
      @(negedge clk);
      chk("rs_valid", {31'd0, iter_valid}, 32'd1);
      idle_inputs();
      rst_n = 1'b0;
      #1;
      chk("rs_valid0", {31'd0, iter_valid}, 32'd0);
      chk("rs_stall", {31'd0, stall_up}, 32'd0);
      chk("rs_cnt", iter_cnt, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rs_done", {31'd0, done}, 32'd0);
      chk("rs_stall2", {31'd0, stall_up}, 32'd0);

      for (int i = 0; i < 30; i++) begin
         logic [31:0] n;
         bit          m;
         m = 1'($urandom_range(1));
         n = m ? 32'($urandom_range(6)) : {16'($urandom), 16'($urandom_range(6))};
         run_seq(n, m, 2'($urandom_range(3)), $urandom, $urandom, 2'($urandom_range(3)),
                 1'($urandom_range(1)), 1'b1, -1, 32'd0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end

endmodule
